// File: rtl/timer_control_if.sv
// Handshake bundle between the countdown timer control FSM and its neighbours:
// button pulses and mode switch in; pause/restart/setting levels and the target out.
interface timer_control_if #(
  parameter int WIDTH = 13
);
  logic             mode_switch;
  logic             pause_pulse;
  logic             restart_pulse;
  logic             count_zero;
  logic             is_pause;
  logic             is_restart;
  logic             is_setting;
  logic             sel_min;
  logic [WIDTH-1:0] q_target;

  modport master (
    output mode_switch, pause_pulse, restart_pulse, count_zero,
    input  is_pause, is_restart, is_setting, sel_min, q_target
  );

  modport slave (
    input  mode_switch, pause_pulse, restart_pulse, count_zero,
    output is_pause, is_restart, is_setting, sel_min, q_target
  );
endinterface

// File: rtl/timer_control_fsm.sv
// Countdown timer control FSM: run/pause/done sequencing plus the user-editable
// mm:ss target, presented to the down counter as a seconds count.
module timer_control_fsm #(
  parameter int WIDTH       = 13,
  parameter int DEFAULT_MIN = 1,
  parameter int DEFAULT_SEC = 0
) (
  input  logic           clk,
  input  logic           rst,
  timer_control_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUNNING = 3'd1;
  localparam logic [2:0] PAUSED  = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] SETTING = 3'd4;

  logic        mode_p0;
  logic        mode_s;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        sel_min;
  logic [6:0]  tgt_min;
  logic [5:0]  tgt_sec;
  logic        edit_en;
  logic [12:0] min_x60;
  logic [12:0] total_sec;

  function automatic logic [5:0] sec_wrap_inc(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [6:0] min_wrap_inc(input logic [6:0] v);
    return (v >= 7'd99) ? 7'd0 : v + 7'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous slide switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p0 <= 1'b0;
      mode_s  <= 1'b0;
    end else begin
      mode_p0 <= bus.mode_switch;
      mode_s  <= mode_p0;
    end
  end

  // Next-state logic; priority mode_s > restart > count_zero > pause
  always_comb begin
    state_nxt = state;
    if (mode_s) begin
      state_nxt = SETTING;
    end else begin
      case (state)
        SETTING: state_nxt = IDLE;
        IDLE:    if (bus.pause_pulse) state_nxt = RUNNING;
        RUNNING: begin
          if (bus.restart_pulse)    state_nxt = IDLE;
          else if (bus.count_zero)  state_nxt = DONE;
          else if (bus.pause_pulse) state_nxt = PAUSED;
        end
        PAUSED: begin
          if (bus.restart_pulse)    state_nxt = IDLE;
          else if (bus.pause_pulse) state_nxt = RUNNING;
        end
        DONE:    if (bus.restart_pulse) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edits only while resident in SETTING with the switch still up
  assign edit_en = (state == SETTING) && mode_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_min <= 1'b0;
      tgt_min <= 7'(DEFAULT_MIN);
      tgt_sec <= 6'(DEFAULT_SEC);
    end else if (state == SETTING && !mode_s) begin
      sel_min <= 1'b0;
    end else if (edit_en) begin
      if (bus.restart_pulse) begin
        sel_min <= ~sel_min;
      end else if (bus.pause_pulse) begin
        if (sel_min) tgt_min <= min_wrap_inc(tgt_min);
        else         tgt_sec <= sec_wrap_inc(tgt_sec);
      end
    end
  end

  // min*60 as (min<<6) - (min<<2); 99:59 fits in 13 bits
  assign min_x60   = ({6'd0, tgt_min} << 6) - ({6'd0, tgt_min} << 2);
  assign total_sec = min_x60 + {7'd0, tgt_sec};

  always_comb begin
    bus.is_pause   = 1'b1;
    bus.is_restart = 1'b0;
    bus.is_setting = 1'b0;
    case (state)
      IDLE:    begin bus.is_pause = 1'b1; bus.is_restart = 1'b1; bus.is_setting = 1'b0; end
      RUNNING: begin bus.is_pause = 1'b0; bus.is_restart = 1'b0; bus.is_setting = 1'b0; end
      PAUSED:  begin bus.is_pause = 1'b1; bus.is_restart = 1'b0; bus.is_setting = 1'b0; end
      DONE:    begin bus.is_pause = 1'b1; bus.is_restart = 1'b0; bus.is_setting = 1'b0; end
      SETTING: begin bus.is_pause = 1'b1; bus.is_restart = 1'b1; bus.is_setting = 1'b1; end
      default: begin bus.is_pause = 1'b1; bus.is_restart = 1'b1; bus.is_setting = 1'b0; end
    endcase
  end

  assign bus.sel_min  = sel_min;
  assign bus.q_target = WIDTH'(total_sec);

endmodule

// File: tb/tb_timer_control_fsm.sv
// Directed bench for timer_control_fsm: run/pause/done flow, target editing,
// input priority and asynchronous reset.
module tb_timer_control_fsm;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  timer_control_if #(.WIDTH(13)) bus ();

  timer_control_fsm #(.WIDTH(13), .DEFAULT_MIN(1), .DEFAULT_SEC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // One-cycle stimulus; returns on the negedge after the capturing posedge
  task automatic drive(input logic p, input logic r, input logic z);
    @(negedge clk);
    bus.pause_pulse   = p;
    bus.restart_pulse = r;
    bus.count_zero    = z;
    @(negedge clk);
    bus.pause_pulse   = 1'b0;
    bus.restart_pulse = 1'b0;
    bus.count_zero    = 1'b0;
  endtask

  task automatic set_mode(input logic v);
    @(negedge clk);
    bus.mode_switch = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.mode_switch = 1'b0; bus.pause_pulse = 1'b0;
    bus.restart_pulse = 1'b0; bus.count_zero = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b110) begin
      errs++; $display("FAIL reset_outputs: got %b required 110", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    vecs++;
    if (bus.q_target !== 13'd60) begin
      errs++; $display("FAIL reset_target: got %0d required 60", bus.q_target);
    end
    vecs++;
    if (bus.sel_min !== 1'b0) begin
      errs++; $display("FAIL reset_sel_min: got %b required 0", bus.sel_min);
    end
  endtask

  task automatic test_run_flow;
    logic [2:0] exp [6] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b100, 3'b110};
    logic [2:0] stim [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b010};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      vecs++;
      if ({bus.is_pause, bus.is_restart, bus.is_setting} !== exp[i]) begin
        errs++; $display("FAIL run_flow_step%0d: got %b required %b", i, {bus.is_pause, bus.is_restart, bus.is_setting}, exp[i]);
      end
    end
    // count_zero is ignored in IDLE
    drive(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b110) begin
      errs++; $display("FAIL zero_in_idle: got %b required 110", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
  endtask

  task automatic test_setting_edit;
    @(negedge clk);
    bus.mode_switch = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (bus.is_setting !== 1'b0) begin
      errs++; $display("FAIL mode_latency_early: got %b required 0", bus.is_setting);
    end
    @(negedge clk);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b111) begin
      errs++; $display("FAIL mode_enter: got %b required 111", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    for (int i = 0; i < 61; i++) drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if (bus.q_target !== 13'd61) begin
      errs++; $display("FAIL sec_wrap: got %0d required 61", bus.q_target);
    end
    drive(1'b0, 1'b1, 1'b0);
    vecs++;
    if (bus.sel_min !== 1'b1) begin
      errs++; $display("FAIL sel_toggle: got %b required 1", bus.sel_min);
    end
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if (bus.q_target !== 13'd61) begin
      errs++; $display("FAIL min_wrap: got %0d required 61", bus.q_target);
    end
    for (int i = 0; i < 98; i++) drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if (bus.q_target !== 13'd5941) begin
      errs++; $display("FAIL min_99: got %0d required 5941", bus.q_target);
    end
    set_mode(1'b0);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting, bus.sel_min} !== 4'b1100) begin
      errs++; $display("FAIL setting_exit: got %b required 1100", {bus.is_pause, bus.is_restart, bus.is_setting, bus.sel_min});
    end
    vecs++;
    if (bus.q_target !== 13'd5941) begin
      errs++; $display("FAIL target_held: got %0d required 5941", bus.q_target);
    end
  endtask

  task automatic test_priority;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b110) begin
      errs++; $display("FAIL prio_restart: got %b required 110", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b100) begin
      errs++; $display("FAIL prio_zero: got %b required 100", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    // Distinguish DONE from PAUSED: pause must not resume
    drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b100) begin
      errs++; $display("FAIL done_hold: got %b required 100", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_same_cycle_edit;
    set_mode(1'b1);
    drive(1'b1, 1'b1, 1'b0);
    vecs++;
    if (bus.sel_min !== 1'b1) begin
      errs++; $display("FAIL both_toggle: got %b required 1", bus.sel_min);
    end
    vecs++;
    if (bus.q_target !== 13'd5941) begin
      errs++; $display("FAIL both_no_inc: got %0d required 5941", bus.q_target);
    end
  endtask

  task automatic test_async_reset;
    // minutes 99 -> 12, seconds 1 -> 34
    for (int i = 0; i < 13; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if (bus.q_target !== 13'd754) begin
      errs++; $display("FAIL target_1234: got %0d required 754", bus.q_target);
    end
    set_mode(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b100) begin
      errs++; $display("FAIL paused_before_rst: got %b required 100", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b110) begin
      errs++; $display("FAIL async_rst_outputs: got %b required 110", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
    vecs++;
    if (bus.q_target !== 13'd60) begin
      errs++; $display("FAIL async_rst_target: got %0d required 60", bus.q_target);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    vecs++;
    if ({bus.is_pause, bus.is_restart, bus.is_setting} !== 3'b000) begin
      errs++; $display("FAIL run_after_rst: got %b required 000", {bus.is_pause, bus.is_restart, bus.is_setting});
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_run_flow();
    test_setting_edit();
    test_priority();
    test_same_cycle_edit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
